// File: rtl/spi_pkg.sv
// spi_pkg: shared SPI link constants and the target-side state encoding.
package spi_pkg;
  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_e;
  localparam int SPI_WIDTH = 8;
  localparam logic [SPI_WIDTH-1:0] TX_IDLE_BYTE_DEF = 8'hFF;
  localparam logic CPOL = 1'b1;
  localparam logic CPHA = 1'b1;
endpackage

// File: rtl/spi_slave_sync.sv
// spi_sync: multi-flop synchronizer for one asynchronous pin with a chosen reset level.
module spi_sync #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);
  logic [STAGES-1:0] sync_d, sync_q;
  always_comb sync_d = {sync_q[STAGES-2:0], d};
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) sync_q <= {STAGES{RST_VAL}};
    else sync_q <= sync_d;
  assign q = sync_q[STAGES-1];
endmodule

// File: rtl/spi_slave.sv
// spi_slave: mode-3 SPI target; oversampled pins, one-deep tx buffer, byte-wide rx strobe.
module spi_slave
  import spi_pkg::*;
#(
  parameter int                    SYNC_STAGES  = 2,
  parameter logic [SPI_WIDTH-1:0]  TX_IDLE_BYTE = TX_IDLE_BYTE_DEF
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 SCLK,
  input  logic                 CS_n,
  input  logic                 MOSI,
  output logic                 MISO,
  output logic                 miso_oe,
  input  logic [SPI_WIDTH-1:0] tx_data,
  input  logic                 tx_load,
  output logic                 tx_ready,
  output logic [SPI_WIDTH-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 tx_underrun,
  output logic                 busy
);
  logic sclk_s, csn_s, mosi_s;
  logic sclk_dly_q, csn_dly_q;
  logic sclk_rise, sclk_fall, cs_fall, cs_rise, reload;
  state_e state_d, state_q;
  logic [2:0] bit_cnt_d, bit_cnt_q;
  logic [SPI_WIDTH-1:0] tx_shift_d, tx_shift_q, rx_shift_d, rx_shift_q;
  logic [SPI_WIDTH-1:0] rx_data_d, rx_data_q, tx_buf_d, tx_buf_q;
  logic tx_full_d, tx_full_q, rx_valid_d, rx_valid_q;
  logic tx_underrun_d, tx_underrun_q, miso_d, miso_q, sel_d, sel_q;

  spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_sclk (.clk(clk), .reset_n(reset_n), .d(SCLK), .q(sclk_s));
  spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_csn  (.clk(clk), .reset_n(reset_n), .d(CS_n), .q(csn_s));
  spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (.clk(clk), .reset_n(reset_n), .d(MOSI), .q(mosi_s));

  assign sclk_rise = sclk_s & ~sclk_dly_q;
  assign sclk_fall = ~sclk_s & sclk_dly_q;
  assign cs_fall   = ~csn_s & csn_dly_q;
  assign cs_rise   = csn_s & ~csn_dly_q;

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    tx_shift_d = tx_shift_q;
    rx_shift_d = rx_shift_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    reload     = 1'b0;
    if (state_q == IDLE) begin
      if (cs_fall) begin
        state_d   = SHIFT;
        bit_cnt_d = 3'd0;
        reload    = 1'b1;
      end
    end else if (cs_rise) begin
      state_d   = IDLE;
      bit_cnt_d = 3'd0;
    end else if (sclk_rise) begin
      rx_shift_d = {rx_shift_q[SPI_WIDTH-2:0], mosi_s};
      bit_cnt_d  = bit_cnt_q + 3'd1;
      if (bit_cnt_q == 3'd7) begin
        rx_data_d  = rx_shift_d;
        rx_valid_d = 1'b1;
        reload     = 1'b1;
      end
    end else if (sclk_fall && bit_cnt_q != 3'd0) begin
      tx_shift_d = {tx_shift_q[SPI_WIDTH-2:0], 1'b0};
    end
    // A reload drains the buffer; an empty buffer can still accept tx_load in the same cycle.
    tx_shift_d    = reload ? (tx_full_q ? tx_buf_q : TX_IDLE_BYTE) : tx_shift_d;
    tx_underrun_d = reload & ~tx_full_q;
    tx_full_d     = tx_full_q ? ~reload : tx_load;
    tx_buf_d      = (~tx_full_q & tx_load) ? tx_data : tx_buf_q;
    sel_d         = state_d == SHIFT;
    miso_d        = sel_d ? tx_shift_d[SPI_WIDTH-1] : 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      sclk_dly_q    <= 1'b1;
      csn_dly_q     <= 1'b1;
      state_q       <= IDLE;
      bit_cnt_q     <= 3'd0;
      tx_shift_q    <= '0;
      rx_shift_q    <= '0;
      rx_data_q     <= '0;
      rx_valid_q    <= 1'b0;
      tx_buf_q      <= '0;
      tx_full_q     <= 1'b0;
      tx_underrun_q <= 1'b0;
      miso_q        <= 1'b1;
      sel_q         <= 1'b0;
    end else begin
      sclk_dly_q    <= sclk_s;
      csn_dly_q     <= csn_s;
      state_q       <= state_d;
      bit_cnt_q     <= bit_cnt_d;
      tx_shift_q    <= tx_shift_d;
      rx_shift_q    <= rx_shift_d;
      rx_data_q     <= rx_data_d;
      rx_valid_q    <= rx_valid_d;
      tx_buf_q      <= tx_buf_d;
      tx_full_q     <= tx_full_d;
      tx_underrun_q <= tx_underrun_d;
      miso_q        <= miso_d;
      sel_q         <= sel_d;
    end

  assign MISO        = miso_q;
  assign miso_oe     = sel_q;
  assign busy        = sel_q;
  assign tx_ready    = ~tx_full_q;
  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign tx_underrun = tx_underrun_q;
endmodule

// File: tb/tb_spi_slave.sv
// tb_spi_slave: mode-3 bus master model with scoreboard queues for received and returned bytes.
module tb_spi_slave;
  localparam int HALF = 4;
  logic clk = 1'b0;
  logic reset_n, SCLK, CS_n, MOSI, MISO, miso_oe, tx_load, tx_ready, rx_valid, tx_underrun, busy;
  logic [7:0] tx_data, rx_data, mbyte;
  int n_chk = 0, n_pass = 0, n_ur = 0, u0;
  logic [7:0] rx_exp[$], miso_exp[$];
  event m_ev;

  always #5 clk = ~clk;

  spi_slave dut (
    .clk(clk), .reset_n(reset_n), .SCLK(SCLK), .CS_n(CS_n), .MOSI(MOSI),
    .MISO(MISO), .miso_oe(miso_oe), .tx_data(tx_data), .tx_load(tx_load),
    .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_underrun(tx_underrun), .busy(busy)
  );

  task automatic chk(input string name, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", name, got, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [7:0] v);
    tx_data = v;
    tx_load = 1'b1;
    tick;
    tx_load = 1'b0;
  endtask

  task automatic cs_lo;
    CS_n = 1'b0;
    repeat (HALF) tick;
  endtask

  task automatic cs_hi;
    CS_n = 1'b1;
    repeat (2 * HALF) tick;
  endtask

  task automatic xbyte(input logic [7:0] d, input int nbits, input bit ld, input logic [7:0] lv);
    logic [7:0] got;
    got = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      SCLK = 1'b0;
      MOSI = d[7-i];
      for (int j = 0; j < HALF; j++) begin
        if (ld && i == 3 && j == 0) begin
          tx_data = lv;
          tx_load = 1'b1;
        end
        tick;
        tx_load = 1'b0;
      end
      SCLK = 1'b1;
      got = {got[6:0], MISO};
      repeat (HALF) tick;
    end
    if (nbits == 8) begin
      mbyte = got;
      ->m_ev;
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_miso"}, MISO, 1);
    chk({tag, "_oe"}, miso_oe, 0);
    chk({tag, "_tx_ready"}, tx_ready, 1);
    chk({tag, "_rx_data"}, rx_data, 0);
    chk({tag, "_rx_valid"}, rx_valid, 0);
    chk({tag, "_underrun"}, tx_underrun, 0);
    chk({tag, "_busy"}, busy, 0);
  endtask

  always @(m_ev)
    if (miso_exp.size() == 0) chk("miso_q_size", 0, 1);
    else chk("miso_byte", mbyte, miso_exp.pop_front());

  always @(negedge clk) begin
    if (tx_underrun) n_ur++;
    if (rx_valid) begin
      if (rx_exp.size() == 0) chk("rx_unexp_valid", rx_valid, 0);
      else chk("rx_byte", rx_data, rx_exp.pop_front());
    end
  end

  initial begin
    reset_n = 1'b0; SCLK = 1'b1; CS_n = 1'b1; MOSI = 1'b0; tx_load = 1'b0; tx_data = 8'h00;
    repeat (3) tick;
    chk_reset_outputs("rst");
    reset_n = 1'b1;
    repeat (3) tick;
    // preloaded byte, tx_ready timing around synchronized CS_n fall
    load(8'h3C);
    chk("A_ready_after_load", tx_ready, 0);
    rx_exp.push_back(8'hA5); miso_exp.push_back(8'h3C);
    u0 = n_ur;
    CS_n = 1'b0;
    tick; tick;
    chk("A_ready_pre", tx_ready, 0);
    chk("A_busy_pre", busy, 0);
    tick;
    chk("A_ready_post", tx_ready, 1);
    chk("A_busy_post", busy, 1);
    chk("A_oe", miso_oe, 1);
    chk("A_miso_msb", MISO, 0);
    tick;
    xbyte(8'hA5, 8, 1, 8'hE1);
    cs_hi;
    chk("A_busy_end", busy, 0);
    chk("A_oe_end", miso_oe, 0);
    chk("A_miso_idle", MISO, 1);
    chk("A_rx_data", rx_data, 8'hA5);
    chk("A_ready_end", tx_ready, 1);
    chk("A_underruns", n_ur - u0, 0);
    // empty buffer at frame start
    u0 = n_ur;
    rx_exp.push_back(8'h01); miso_exp.push_back(8'hFF);
    cs_lo;
    xbyte(8'h01, 8, 1, 8'hE2);
    cs_hi;
    chk("B_underruns", n_ur - u0, 1);
    chk("B_rx_data", rx_data, 8'h01);
    // two bytes, second tx byte loaded during the first
    u0 = n_ur;
    load(8'hC3);
    rx_exp.push_back(8'h12); rx_exp.push_back(8'h34);
    miso_exp.push_back(8'hC3); miso_exp.push_back(8'h5A);
    cs_lo;
    xbyte(8'h12, 8, 1, 8'h5A);
    xbyte(8'h34, 8, 1, 8'hE3);
    cs_hi;
    chk("C_underruns", n_ur - u0, 0);
    // aborted frame after 5 bits, then a clean frame
    u0 = n_ur;
    cs_lo;
    xbyte(8'hAB, 5, 0, 8'h00);
    cs_hi;
    chk("D_busy_abort", busy, 0);
    chk("D_rx_kept", rx_data, 8'h34);
    rx_exp.push_back(8'hF0); miso_exp.push_back(8'hFF);
    cs_lo;
    xbyte(8'hF0, 8, 1, 8'hE4);
    cs_hi;
    chk("D_underruns", n_ur - u0, 2);
    chk("D_rx_data", rx_data, 8'hF0);
    // second load while buffer full is dropped
    u0 = n_ur;
    load(8'h11);
    load(8'h22);
    chk("E_ready_full", tx_ready, 0);
    rx_exp.push_back(8'h5C); miso_exp.push_back(8'h11);
    cs_lo;
    xbyte(8'h5C, 8, 1, 8'hE5);
    cs_hi;
    chk("E_underruns", n_ur - u0, 0);
    // reset mid-byte
    load(8'h77);
    cs_lo;
    xbyte(8'h00, 3, 0, 8'h00);
    reset_n = 1'b0; CS_n = 1'b1; SCLK = 1'b1;
    #1;
    chk_reset_outputs("F_midrst");
    tick; tick;
    reset_n = 1'b1;
    repeat (3) tick;
    u0 = n_ur;
    rx_exp.push_back(8'h99); miso_exp.push_back(8'hFF);
    cs_lo;
    xbyte(8'h99, 8, 1, 8'hE6);
    cs_hi;
    chk("F_underruns", n_ur - u0, 1);
    chk("F_rx_data", rx_data, 8'h99);
    chk("rx_q_drained", rx_exp.size(), 0);
    chk("miso_q_drained", miso_exp.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/spi_slave.md
Name: spi_slave

Overview:
- SPI target (slave) end of the team's SPI link; pairs with the existing prescaled SPI master.
- Mode 3: SCLK idles high, data changes on the falling edge, data is sampled on the rising edge, MSB first, 8-bit frames.
- Oversamples the external SCLK/CS_n/MOSI pins with the system clock and serialises a one-deep transmit buffer onto MISO.
- Presents each received byte as a one-cycle valid pulse on the fabric side.

Parameters:
- SYNC_STAGES, 2, number of synchronizer flops on SCLK, CS_n and MOSI (minimum 2).
- TX_IDLE_BYTE, 8'hFF, byte shifted out when no transmit byte is pending at a frame boundary.

Ports:
- clk  input  1  system clock.
- reset_n  input  1  asynchronous, active-low reset.
- SCLK  input  1  SPI clock from the master, asynchronous to clk.
- CS_n  input  1  chip select from the master, active low, asynchronous.
- MOSI  input  1  serial data from the master, asynchronous.
- MISO  output  1  serial data to the master.
- miso_oe  output  1  MISO output enable; high while selected.
- tx_data  input  8  byte to transmit next.
- tx_load  input  1  write strobe for tx_data.
- tx_ready  output  1  transmit buffer empty; tx_load is accepted.
- rx_data  output  8  last complete received byte.
- rx_valid  output  1  one-cycle pulse when rx_data updates.
- tx_underrun  output  1  one-cycle pulse when TX_IDLE_BYTE was loaded for lack of data.
- busy  output  1  frame in progress (synchronized CS_n low).

Behaviour:
- Reset values (async, reset_n low): MISO=1, miso_oe=0, tx_ready=1, rx_data=0, rx_valid=0, tx_underrun=0, busy=0, state=IDLE, bit_cnt=0, tx buffer empty. Synchronizer flops reset to 1 for SCLK/CS_n and 0 for MOSI.
- Synchronizers:
  - SCLK, CS_n and MOSI each pass through SYNC_STAGES flops.
  - One extra flop on synchronized SCLK and CS_n provides edge detection.
  - Pin-to-action latency is SYNC_STAGES+1 clk.
- Timing requirement: SCLK high and low phases are each ≥ SYNC_STAGES+2 clk cycles. This means the master's prescaler is ≥ 3 for SYNC_STAGES=2. Behaviour is undefined otherwise.
- State IDLE:
  - miso_oe=0, MISO=1, busy=0.
  - On synchronized CS_n falling: go to SHIFT, bit_cnt=0.
  - Load tx_shift from the tx buffer if it is full (then clear the buffer, so tx_ready rises next cycle). Otherwise load TX_IDLE_BYTE and pulse tx_underrun.
- State SHIFT:
  - miso_oe=1, busy=1, MISO=tx_shift[7].
  - SCLK rising (sync): rx_shift <= {rx_shift[6:0], MOSI_sync}; bit_cnt <= bit_cnt+1 (3-bit, wraps 7→0).
  - On the 8th rising edge (bit_cnt==7):
    - rx_data <= {rx_shift[6:0], MOSI_sync}; rx_valid pulses for 1 clk.
    - Reload tx_shift using the same buffer/TX_IDLE_BYTE/tx_underrun rule as frame start.
  - SCLK falling (sync) with bit_cnt != 0: tx_shift <= {tx_shift[6:0], 1'b0}.
  - SCLK falling with bit_cnt == 0 (first edge of a byte): no shift; MSB is already on MISO.
  - CS_n rising (sync), any bit_cnt: go to IDLE.
    - Partial byte discarded; no rx_valid.
    - bit_cnt=0; tx buffer contents retained.
- tx buffer:
  - tx_load while tx_ready=1: capture tx_data, tx_ready=0 next cycle.
  - tx_load while tx_ready=0: ignored; buffer unchanged.
  - tx_load in the same cycle as a reload with an empty buffer: the reload uses TX_IDLE_BYTE (underrun pulse) and the new byte enters the buffer.
  - Reload with a full buffer and a simultaneous tx_load: the buffer empties and tx_load is ignored, because tx_ready was 0.
- Back-to-back bytes: continuous SCLK across byte boundaries under the same CS_n is supported with no gap required.
- Edge ordering: CS_n rising takes priority over an SCLK edge detected in the same cycle.
- Reset mid-frame: all state cleared immediately; the frame is lost.

Decomposition:
- Package spi_pkg holds:
  - state encoding (IDLE=1'b0, SHIFT=1'b1);
  - SPI_WIDTH=8;
  - default TX_IDLE_BYTE;
  - SPI mode constants (CPOL=1, CPHA=1), shared with the master.
- Sub-module spi_sync: parameterised SYNC_STAGES flop chain with reset value parameter, instantiated three times.

Test Plan:
- Master sends 8'hA5 with tx buffer preloaded 8'h3C, prescaler 3 → rx_data=8'hA5 with one rx_valid pulse after the 8th rising edge; master receives 8'h3C; tx_ready rises 1 clk after CS_n sync falls.
- Empty tx buffer, master sends 8'h01 → master receives 8'hFF, tx_underrun pulses once, rx_data=8'h01.
- Two-byte frame 8'h12, 8'h34 with buffer loaded 8'hC3 then 8'h5A (second load during byte 1) → two rx_valid pulses (8'h12, 8'h34); master receives 8'hC3, 8'h5A; no underrun.
- CS_n deasserted after 5 SCLK rising edges → no rx_valid, busy falls; next full frame 8'hF0 → rx_data=8'hF0 with correct bit alignment.
- tx_load 8'h11 then tx_load 8'h22 while tx_ready=0 → master receives 8'h11; 8'h22 is dropped.
- reset_n asserted mid-byte → all outputs return to reset values within the reset cycle; a subsequent frame of 8'h99 is received correctly.
